led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter ROWS, default 16: matrix row count, legal range >=6.
REQ-002 SHALL have parameter COLS, default 16: matrix column count, legal range >=6.
REQ-003 SHALL have parameter TICK_DIV, default 4: enabled clock cycles per animation step, legal range >=1.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  animation/update enable.
REQ-007 SHALL have port mode  input  2  pattern select: 0 box, 1 checker, 2 column scroll, 3 row sweep.
REQ-008 SHALL have port RedPixels  output  [ROWS-1:0][COLS-1:0]  red LED array, indexed [row][col].
REQ-009 SHALL have port GrnPixels  output  [ROWS-1:0][COLS-1:0]  green LED array, indexed [row][col].
REQ-010 SHALL have port step  output  1  one-cycle pulse on each animation step.

Function
REQ-011 SHALL hold internal state: tick_cnt (0..TICK_DIV-1), pos (0..max(ROWS,COLS)-1), phase (1 bit), mode_q (2 bits).
REQ-012 SHALL register both pixel outputs; each enabled cycle, outputs load the pattern computed from the pre-edge mode_q/pos/phase, giving 1-cycle latency from state to pixels.
REQ-013 SHALL, when en=1 and tick_cnt=TICK_DIV-1, clear tick_cnt, assert step for that cycle, toggle phase, and advance pos; otherwise, when en=1, increment tick_cnt.
REQ-014 SHALL wrap pos to 0 after COLS-1 in mode 2 and after ROWS-1 in mode 3; pos SHALL stay 0 in modes 0 and 1.
REQ-015 SHALL, when en=0, freeze tick_cnt, pos, phase, and both pixel outputs, and hold step low.
REQ-016 SHALL, when mode!=mode_q, in that cycle load mode_q<=mode and clear tick_cnt, pos, and phase, and hold step low; this takes priority over a coinciding step, regardless of en.
REQ-017 Mode 0 SHALL light red and green for rows and cols in [N/2-3, N/2+2] (16x16: rows/cols 5..10), all else 0.
REQ-018 Mode 1 SHALL set Red[r][c]=1 iff (r+c) mod 2 == phase, and Grn[r][c] to the complement.
REQ-019 Mode 2 SHALL set Red[r][pos]=1 for all r, all other red bits 0, and all green bits 0.
REQ-020 Mode 3 SHALL set Grn[pos][c]=1 for all c, all other green bits 0, and all red bits 0.
REQ-021 SHALL, with TICK_DIV=1, step on every enabled cycle.

Reset
REQ-022 SHALL, on RST=1 at a clock edge, clear RedPixels, GrnPixels, step, tick_cnt, pos, and phase, and set mode_q<=mode.
REQ-023 SHALL let RST override en and mode-change handling, including mid-animation; the first enabled cycle after release outputs pattern(mode_q, pos=0, phase=0).

Configuration
REQ-024 SHALL, with macro LED_PATTERN_BLINK_EN defined, show the mode 0 box only when phase=0 and blank both arrays when phase=1, giving a blinking box at half step rate.
REQ-025 SHALL, without LED_PATTERN_BLINK_EN, ignore phase in mode 0, giving a steady box; all other modes are identical either way.

Verification
REQ-026 SHALL cover reset: RST=1 for 2 cycles with mode=2 -> both arrays 0 and step=0; release with en=1 -> next cycle Red column 0 fully lit, Grn 0.
REQ-027 SHALL cover stepping: 16x16, TICK_DIV=4, mode=2, en=1 -> step every 4th cycle; lit column 0,1,...,15,0; wrap after column 15.
REQ-028 SHALL cover checker: mode=1 -> Red[0][0]=1, Grn[0][0]=0; after one step Red[0][0]=0, Grn[0][0]=1.
REQ-029 SHALL cover freeze: mode=3 at pos=7, en=0 for 10 cycles -> Grn row 7 held, no step pulses; en=1 -> resume, row 8 after tick_cnt completes.
REQ-030 SHALL cover mode change: mode 2->3 on the cycle tick_cnt=3 -> no step pulse; pos=0 and phase=0, and Grn row 0 lit one cycle later.
REQ-031 SHALL cover box and blink: mode=0 -> rows/cols 5..10 lit in both colours; with LED_PATTERN_BLINK_EN, all-zero on alternate steps; without it, constant.

Source files
------------

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// Animated test-pattern generator for a ROWS x COLS bicolour LED matrix.
// A tick divider turns every TICK_DIV enabled clock cycles into one
// animation step; each step toggles a phase bit and advances a position
// counter used by the scrolling patterns.
//
// Patterns (mode):
//   0  box         : centred 6x6 filled box, red and green
//   1  checker     : red/green checkerboard, swaps colour every step
//   2  col scroll  : single red column walking left to right
//   3  row sweep   : single green row walking top to bottom
//
// Ports:
//   CLK        in   single clock, all state updates on rising edge
//   RST        in   synchronous active-high reset
//   en         in   animation/update enable; 0 freezes counters and pixels
//   mode[1:0]  in   pattern select (see above)
//   RedPixels  out  [ROWS-1:0][COLS-1:0] registered red array, [row][col]
//   GrnPixels  out  [ROWS-1:0][COLS-1:0] registered green array, [row][col]
//   step       out  one-cycle pulse following each animation step
//
// Build option:
//   LED_PATTERN_BLINK_EN  when defined, the mode 0 box is shown only while
//                         phase=0 and blanked while phase=1 (blinking box).
//                         When undefined the box is steady.
// ---------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int TICK_DIV = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       en,
    input  logic [1:0]                 mode,
    output logic [ROWS-1:0][COLS-1:0]  RedPixels,
    output logic [ROWS-1:0][COLS-1:0]  GrnPixels,
    output logic                       step
);

    // -----------------------------------------------------------------------
    // Derived sizes and constants
    // -----------------------------------------------------------------------
    localparam int MAX_DIM = (ROWS > COLS) ? ROWS : COLS;
    localparam int POS_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam int unsigned LAST_TICK = TICK_DIV - 1;
    localparam int unsigned LAST_COL  = COLS - 1;
    localparam int unsigned LAST_ROW  = ROWS - 1;

    // Box spans [N/2-3, N/2+2] on each axis (rows 5..10 on a 16-row panel)
    localparam int unsigned BOX_R_LO = ROWS / 2 - 3;
    localparam int unsigned BOX_R_HI = ROWS / 2 + 2;
    localparam int unsigned BOX_C_LO = COLS / 2 - 3;
    localparam int unsigned BOX_C_HI = COLS / 2 + 2;

    localparam logic [1:0] MODE_BOX     = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_SCROLL  = 2'd2;
    localparam logic [1:0] MODE_SWEEP   = 2'd3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic [POS_W-1:0]  pos;
    logic              phase;
    logic [1:0]        mode_q;

    // -----------------------------------------------------------------------
    // Next-state helpers
    // -----------------------------------------------------------------------
    logic                      tick_last;
    logic                      mode_change;
    logic [POS_W-1:0]          pos_adv;
    logic                      box_visible;
    logic [ROWS-1:0]           row_in_box;
    logic [COLS-1:0]           col_in_box;
    logic [ROWS-1:0][COLS-1:0] red_next;
    logic [ROWS-1:0][COLS-1:0] grn_next;

    assign tick_last   = (32'(tick_cnt) == LAST_TICK);
    assign mode_change = (mode != mode_q);

`ifdef LED_PATTERN_BLINK_EN
    assign box_visible = ~phase;
`else
    assign box_visible = 1'b1;
`endif

    // Position only moves in the scrolling modes; each wraps on its own axis
    always_comb begin
        pos_adv = '0;
        case (mode_q)
            MODE_SCROLL: pos_adv = (32'(pos) == LAST_COL) ? '0 : pos + 1'b1;
            MODE_SWEEP:  pos_adv = (32'(pos) == LAST_ROW) ? '0 : pos + 1'b1;
            default:     pos_adv = '0;
        endcase
    end

    // Box membership masks per axis
    always_comb begin
        row_in_box = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_in_box[r] = (r >= BOX_R_LO) && (r <= BOX_R_HI);
        end
    end

    always_comb begin
        col_in_box = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            col_in_box[c] = (c >= BOX_C_LO) && (c <= BOX_C_HI);
        end
    end

    // Pattern generated from the current (pre-edge) mode_q/pos/phase
    always_comb begin
        red_next = '0;
        grn_next = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                case (mode_q)
                    MODE_BOX: begin
                        red_next[r][c] = row_in_box[r] & col_in_box[c] & box_visible;
                        grn_next[r][c] = row_in_box[r] & col_in_box[c] & box_visible;
                    end
                    MODE_CHECKER: begin
                        // (r+c) mod 2 is the XOR of the index LSBs
                        red_next[r][c] = ~(r[0] ^ c[0] ^ phase);
                        grn_next[r][c] =  (r[0] ^ c[0] ^ phase);
                    end
                    MODE_SCROLL: begin
                        red_next[r][c] = (c == 32'(pos));
                        grn_next[r][c] = 1'b0;
                    end
                    MODE_SWEEP: begin
                        red_next[r][c] = 1'b0;
                        grn_next[r][c] = (r == 32'(pos));
                    end
                    default: begin
                        red_next[r][c] = 1'b0;
                        grn_next[r][c] = 1'b0;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            RedPixels <= '0;
            GrnPixels <= '0;
            step      <= 1'b0;
            tick_cnt  <= '0;
            pos       <= '0;
            phase     <= 1'b0;
            mode_q    <= mode;
        end else begin
            step <= 1'b0;

            // Pixels follow the enable alone: on a mode-change cycle they
            // still load the pattern of the outgoing mode, and the new mode
            // appears one cycle later.
            if (en) begin
                RedPixels <= red_next;
                GrnPixels <= grn_next;
            end

            if (mode_change) begin
                mode_q   <= mode;
                tick_cnt <= '0;
                pos      <= '0;
                phase    <= 1'b0;
            end else if (en) begin
                if (tick_last) begin
                    tick_cnt <= '0;
                    step     <= 1'b1;
                    phase    <= ~phase;
                    pos      <= pos_adv;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
`timescale 1ns/1ps
module tb_led_pattern_gen;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int TD   = 4;
    localparam int NB   = ROWS * COLS;
    localparam int R1   = 6;
    localparam int C1   = 7;

`ifdef LED_PATTERN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    logic en;
    logic [1:0] mode;
    logic [ROWS-1:0][COLS-1:0] RedPixels;
    logic [ROWS-1:0][COLS-1:0] GrnPixels;
    logic step;
    logic [R1-1:0][C1-1:0] red1;
    logic [R1-1:0][C1-1:0] grn1;
    logic step1;

    always #5 CLK = ~CLK;

    led_pattern_gen #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD)) dut (
        .CLK(CLK), .RST(RST), .en(en), .mode(mode),
        .RedPixels(RedPixels), .GrnPixels(GrnPixels), .step(step)
    );

    // Small panel, one step per enabled cycle
    led_pattern_gen #(.ROWS(R1), .COLS(C1), .TICK_DIV(1)) dut1 (
        .CLK(CLK), .RST(RST), .en(en), .mode(mode),
        .RedPixels(red1), .GrnPixels(grn1), .step(step1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers)
    int m_tick, m_pos, m_phase, m_mode;
    logic m_step;
    logic [ROWS-1:0][COLS-1:0] m_red, m_grn;

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit in_box(int r, int c, int ph);
        bit inside_box;
        inside_box = (r >= ROWS/2 - 3) && (r <= ROWS/2 + 2) &&
                     (c >= COLS/2 - 3) && (c <= COLS/2 + 2);
        return inside_box && (!BLINK || ph == 0);
    endfunction

    function automatic bit want_red(int md, int p, int ph, int r, int c);
        case (md)
            0:       return in_box(r, c, ph);
            1:       return ((r + c) % 2) == ph;
            2:       return c == p;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit want_grn(int md, int p, int ph, int r, int c);
        case (md)
            0:       return in_box(r, c, ph);
            1:       return ((r + c) % 2) != ph;
            3:       return r == p;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present before it
    task automatic model_step();
        if (RST) begin
            m_red = '0; m_grn = '0; m_step = 1'b0;
            m_tick = 0; m_pos = 0; m_phase = 0; m_mode = int'(mode);
        end else begin
            m_step = 1'b0;
            if (en) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) begin
                        m_red[r][c] = want_red(m_mode, m_pos, m_phase, r, c);
                        m_grn[r][c] = want_grn(m_mode, m_pos, m_phase, r, c);
                    end
            end
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_tick = 0; m_pos = 0; m_phase = 0;
            end else if (en) begin
                if (m_tick == TD - 1) begin
                    m_tick  = 0;
                    m_step  = 1'b1;
                    m_phase = 1 - m_phase;
                    if (m_mode == 2)      m_pos = (m_pos + 1) % COLS;
                    else if (m_mode == 3) m_pos = (m_pos + 1) % ROWS;
                    else                  m_pos = 0;
                end else begin
                    m_tick++;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        check_vec("model_red", RedPixels, m_red);
        check_vec("model_grn", GrnPixels, m_grn);
        check_int("model_step", int'(step), int'(m_step));
    endtask

    task automatic do_reset(input logic [1:0] m);
        RST = 1'b1; en = 1'b0; mode = m;
        cycle();
        cycle();
        check_int("reset_red_zero", $countones(RedPixels), 0);
        check_int("reset_grn_zero", $countones(GrnPixels), 0);
        check_int("reset_step_low", int'(step), 0);
        RST = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       step;
        int         red_cnt;
        int         grn_cnt;
        logic       red00;
        logic       grn00;
    } vec_t;

    vec_t tbl[16];
    logic [NB-1:0] flat;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 1'b0,   0,   0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'd2, 1'b0,   0,   0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd2, 1'b0,  16,   0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd2, 1'b0,  16,   0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 1'b0,  16,   0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'd2, 1'b1,  16,   0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0,  16,   0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0,  16,   0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 128, 128, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'd1, 1'b0, 128, 128, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 128, 128, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'd1, 1'b1, 128, 128, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 128, 128, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 2'd1, 1'b0, 128, 128, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 2'd3, 1'b0,   0,   0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'd3, 1'b0,   0,  16, 1'b0, 1'b1};

        RST = 1'b1; en = 1'b0; mode = 2'd0;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            RST = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode;
            cycle();
            check_int("tbl_step", int'(step), int'(tbl[i].step));
            flat = RedPixels;
            check_int("tbl_red_cnt", $countones(flat), tbl[i].red_cnt);
            flat = GrnPixels;
            check_int("tbl_grn_cnt", $countones(flat), tbl[i].grn_cnt);
            check_int("tbl_red00", int'(RedPixels[0][0]), int'(tbl[i].red00));
            check_int("tbl_grn00", int'(GrnPixels[0][0]), int'(tbl[i].grn00));
        end

        // Column scroll with wrap; TICK_DIV=1 instance steps every cycle
        do_reset(2'd2);
        en = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            for (int j = 0; j < 4; j++) begin
                cycle();
                if (j == 0) check_int("scroll_col_lit", int'(RedPixels[5][k % COLS]), 1);
                check_int("scroll_step_cadence", int'(step), (j == 3) ? 1 : 0);
                check_int("td1_step", int'(step1), 1);
                check_int("td1_col", int'(red1[2][(4*k + j) % C1]), 1);
                check_int("td1_col_cnt", $countones(red1), R1);
            end
        end

        // Freeze at row 7, then resume
        do_reset(2'd3);
        en = 1'b1;
        repeat (29) cycle();
        check_int("freeze_row7_before", int'(GrnPixels[7] == {COLS{1'b1}}), 1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_int("freeze_row7_held", int'(GrnPixels[7] == {COLS{1'b1}}), 1);
            check_int("freeze_no_step", int'(step), 0);
        end
        en = 1'b1;
        cycle();
        cycle();
        check_int("resume_no_step_yet", int'(step), 0);
        cycle();
        check_int("resume_step", int'(step), 1);
        check_int("resume_row7_still", int'(GrnPixels[7] == {COLS{1'b1}}), 1);
        cycle();
        check_int("resume_row8", int'(GrnPixels[8] == {COLS{1'b1}}), 1);
        check_int("resume_row7_off", int'(GrnPixels[7] == {COLS{1'b0}}), 1);

        // Mode change on the would-be step cycle
        do_reset(2'd2);
        en = 1'b1;
        repeat (3) cycle();
        mode = 2'd3;
        cycle();
        check_int("modechg_no_step", int'(step), 0);
        check_int("modechg_old_col", int'(RedPixels[9][0]), 1);
        cycle();
        check_int("modechg_row0", int'(GrnPixels[0] == {COLS{1'b1}}), 1);
        flat = RedPixels;
        check_int("modechg_red_off", $countones(flat), 0);

        // Box, steady or blinking depending on build
        do_reset(2'd0);
        en = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            int vis;
            cycle();
            vis = (BLINK && (((e - 1) / 4) % 2 == 1)) ? 0 : 1;
            check_int("box_red_5_5", int'(RedPixels[5][5]), vis);
            check_int("box_grn_10_10", int'(GrnPixels[10][10]), vis);
            check_int("box_edge_4_5", int'(RedPixels[4][5]), 0);
            check_int("box_edge_10_11", int'(GrnPixels[10][11]), 0);
            flat = RedPixels;
            check_int("box_red_cnt", $countones(flat), vis * 36);
        end

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
